// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc types for the memory-access stage: FSM states, register
// index width and the write-back packet handed to the write-back stage.
package simplerisc_pkg;

  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned WORD_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]    data;
    logic [REG_IDX_W-1:0] rd;
    logic                 wb_en;
    logic                 fault;
  } wb_pkt_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating REQ-cycle counter; expired_o flags the cycle in which the count
// reaches TIMEOUT_CYCLES, i.e. the last cycle a request may stay outstanding.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed REQ cycles, so +1 includes the current one.
  assign expired_o = en_i && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

endmodule

// File: rtl/mem_access_stage.sv
// SimpleRisc memory-access stage: issues ld/st over a req/ack handshake with a
// watchdog and returns a write-back packet. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage
  import simplerisc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic [DATA_W-1:0]    store_data,
  input  logic                 is_ld,
  input  logic                 is_st,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wb_en,
  output logic                 out_fault
);

  mem_state_t        state_q, state_d;
  wb_pkt_t           pkt_q, pkt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              accept_ok;
  logic              addr_trap;
  logic              wd_expired;

`ifdef MISALIGN_TRAP_EN
  assign addr_trap = (alu_result[1:0] != 2'b00);
`else
  assign addr_trap = 1'b0;
`endif

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != REQ),
    .en_i     (state_q == REQ),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    accept_ok = 1'b0;

    case (state_q)
      IDLE: accept_ok = 1'b1;
      REQ: begin
        // Ack takes priority over a watchdog expiry in the same cycle.
        if (mem_ack) begin
          state_d     = RESP;
          pkt_d.data  = we_q ? '0 : mem_rdata;
          pkt_d.wb_en = ~we_q;
          pkt_d.fault = 1'b0;
        end else if (wd_expired) begin
          state_d     = RESP;
          pkt_d.data  = '0;
          pkt_d.wb_en = 1'b0;
          pkt_d.fault = 1'b1;
        end
      end
      RESP: begin
        if (out_ready) begin
          accept_ok = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared by IDLE and an accepted RESP, enabling back-to-back issue.
    if (accept_ok && in_valid) begin
      pkt_d.rd = rd;
      if (is_ld && is_st) begin
        state_d = RESP;
        pkt_d   = '{data: '0, rd: rd, wb_en: 1'b0, fault: 1'b1};
      end else if (is_ld || is_st) begin
        if (addr_trap) begin
          state_d = RESP;
          pkt_d   = '{data: '0, rd: rd, wb_en: 1'b0, fault: 1'b1};
        end else begin
          state_d = REQ;
          pkt_d   = '{data: '0, rd: rd, wb_en: 1'b0, fault: 1'b0};
          addr_d  = {alu_result[DATA_W-1:2], 2'b00};
          wdata_d = store_data;
          we_d    = is_st;
        end
      end else begin
        state_d = RESP;
        pkt_d   = '{data: alu_result, rd: rd, wb_en: wb_en, fault: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign in_ready  = accept_ok && !rst;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign out_valid = (state_q == RESP);
  assign out_data  = pkt_q.data;
  assign out_rd    = pkt_q.rd;
  assign out_wb_en = pkt_q.wb_en;
  assign out_fault = pkt_q.fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        is_ld = 1'b0;
  logic        is_st = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_rd;
  logic        out_wb_en;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(
    .TIMEOUT_CYCLES(4),
    .DATA_W        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_result(alu_result),
    .store_data(store_data),
    .is_ld     (is_ld),
    .is_st     (is_st),
    .wb_en     (wb_en),
    .rd        (rd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_wb_en (out_wb_en),
    .out_fault (out_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] sd,
                          input logic ld, input logic st, input logic we,
                          input logic [3:0] r);
    in_valid = 1'b1; alu_result = a; store_data = sd;
    is_ld = ld; is_st = st; wb_en = we; rd = r;
  endtask

  task automatic idle_op();
    in_valid = 1'b0; is_ld = 1'b0; is_st = 1'b0; wb_en = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({mem_req, out_valid, out_fault, out_wb_en} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, out_valid, out_fault, out_wb_en}); end
    checks++; if (out_data !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", out_data, mem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    drive_op(32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3);
    step(); idle_op();
    checks++; if (out_valid !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL pass_valid got=v%b r%b exp=v1 r0", out_valid, mem_req); end
    checks++; if (out_data !== 32'h7 || out_rd !== 4'd3 || out_wb_en !== 1'b1 || out_fault !== 1'b0) begin errors++; $display("FAIL pass_pkt got=%h/%0d/%b/%b exp=7/3/1/0", out_data, out_rd, out_wb_en, out_fault); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_load_wait();
    int n = 0;
    drive_op(32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 4'd5);
    step(); idle_op();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL ld_req got=%b/%b/%h exp=1/0/100", mem_req, mem_we, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1) n++;
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      step();
    end
    mem_ack = 1'b0;
    checks++; if (n !== 3 || mem_req !== 1'b0) begin errors++; $display("FAIL ld_req_cycles got=%0d/%b exp=3/0", n, mem_req); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_wb_en !== 1'b1 || out_rd !== 4'd5 || out_fault !== 1'b0) begin errors++; $display("FAIL ld_pkt got=%b/%h/%b/%0d/%b exp=1/deadbeef/1/5/0", out_valid, out_data, out_wb_en, out_rd, out_fault); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_hold got=%b/%h exp=1/deadbeef", out_valid, out_data); end
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_op(32'h200, 32'h55, 1'b0, 1'b1, 1'b0, 4'd1);
    step(); idle_op();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h55) begin errors++; $display("FAIL st_req got=%b/%b/%h/%h exp=1/1/200/55", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_wb_en !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL st_pkt got=%b/%b/%h/%b exp=1/0/0/1", out_valid, out_wb_en, out_data, in_ready); end
    drive_op(32'h204, 32'h0, 1'b1, 1'b0, 1'b0, 4'd2);
    step(); idle_op();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h204 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ld_req got=%b/%b/%h/%b exp=1/0/204/0", mem_req, mem_we, mem_addr, out_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
    step(); mem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_rd !== 4'd2 || out_wb_en !== 1'b1) begin errors++; $display("FAIL b2b_ld_pkt got=%b/%h/%0d/%b exp=1/1234/2/1", out_valid, out_data, out_rd, out_wb_en); end
    step(); out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    drive_op(32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 4'd7);
    step(); idle_op();
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) begin n++; step(); end
    checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_wb_en !== 1'b0 || out_data !== 32'h0 || out_rd !== 4'd7) begin errors++; $display("FAIL to_pkt got=%b/%b/%b/%h/%0d exp=1/1/0/0/7", out_valid, out_fault, out_wb_en, out_data, out_rd); end
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL late_ack got=%b/%b/%b exp=0/0/1", mem_req, out_valid, in_ready); end
  endtask

  task automatic test_ack_at_timeout();
    drive_op(32'h400, 32'h0, 1'b1, 1'b0, 1'b0, 4'd8);
    step(); idle_op();
    step(); step(); step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL edge_req4 got=%b exp=1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    step(); mem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b0 || out_data !== 32'hA5A5_0001 || out_wb_en !== 1'b1) begin errors++; $display("FAIL edge_ack_wins got=%b/%b/%h/%b exp=1/0/a5a50001/1", out_valid, out_fault, out_data, out_wb_en); end
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
  endtask

  task automatic test_illegal_and_misalign();
    out_ready = 1'b1;
    drive_op(32'h500, 32'h0, 1'b1, 1'b1, 1'b1, 4'd9);
    step(); idle_op();
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_wb_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL illegal got=%b/%b/%b/%b exp=1/1/0/0", out_valid, out_fault, out_wb_en, mem_req); end
    step();
    drive_op(32'h102, 32'h0, 1'b1, 1'b0, 1'b0, 4'd4);
    step(); idle_op();
`ifdef MISALIGN_TRAP_EN
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_wb_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL misalign_trap got=%b/%b/%b/%b exp=1/1/0/0", out_valid, out_fault, out_wb_en, mem_req); end
    step();
`else
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL misalign_addr got=%b/%h exp=1/100", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
    step(); mem_ack = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b0 || out_data !== 32'hCAFE) begin errors++; $display("FAIL misalign_done got=%b/%b/%h exp=1/0/cafe", out_valid, out_fault, out_data); end
    step();
`endif
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    drive_op(32'h600, 32'h0, 1'b1, 1'b0, 1'b0, 4'd6);
    step(); idle_op();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_async got=%b/%b/%b exp=0/0/0", mem_req, out_valid, in_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    drive_op(32'h0000_00AB, 32'h0, 1'b0, 1'b0, 1'b1, 4'd10);
    step(); idle_op();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hAB || out_rd !== 4'd10 || out_wb_en !== 1'b1) begin errors++; $display("FAIL rst_new_op got=%b/%h/%0d/%b exp=1/ab/10/1", out_valid, out_data, out_rd, out_wb_en); end
    step(); out_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_passthrough();
    test_load_wait();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_illegal_and_misalign();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the SimpleRisc pipeline, directly downstream of the execute-stage ALU. Takes the ALU result as a load/store address, or as a pass-through value for non-memory ops, and runs a valid/ready handshake with the data memory. Returns a write-back packet (data, destination register, write enable, fault) to the write-back stage. A watchdog bounds every memory transaction.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles `mem_req` stays high without `mem_ack` before the access is abandoned (range 1..255).
- DATA_W, 32: data and address width; fixed at 32 for SimpleRisc.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  stage can accept an op this cycle.
- alu_result  in  32  address for ld/st; write-back value otherwise.
- store_data  in  32  data for st.
- is_ld  in  1  op is a load.
- is_st  in  1  op is a store.
- wb_en  in  1  op writes a register (non-memory ops).
- rd  in  4  destination register index.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completes request this cycle.
- mem_rdata  in  32  load data; valid with mem_ack.
- out_valid  out  1  write-back packet valid.
- out_ready  in  1  write-back stage accepts the packet.
- out_data  out  32  load data or pass-through value.
- out_rd  out  4  destination register.
- out_wb_en  out  1  register write enable.
- out_fault  out  1  access failed (timeout, misaligned, illegal).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all inputs.
  - ld or st (exactly one set): go to REQ.
  - Neither set: go to RESP with out_data=alu_result, out_wb_en=wb_en.
  - Both set: go to RESP with out_fault=1, out_wb_en=0, and no memory access.
- REQ:
  - mem_req=1; mem_we=is_st; mem_addr={alu_result[31:2],2'b00}; mem_wdata=store_data.
  - All request outputs are held stable until mem_ack.
  - On mem_ack: go to RESP.
    - Load: out_data=mem_rdata, out_wb_en=1.
    - Store: out_data=0, out_wb_en=0.
  - The watchdog counts REQ cycles. When the count reaches TIMEOUT_CYCLES without mem_ack:
    - drop mem_req;
    - go to RESP with out_fault=1, out_wb_en=0, out_data=0.
  - If mem_ack arrives in the same cycle the count reaches TIMEOUT_CYCLES, the ack wins and there is no fault.
- RESP:
  - out_valid=1; all out_* held stable until out_ready.
  - On out_ready, in_ready=1 in the same cycle, which allows back-to-back issue:
    - in_valid also high: capture the new op and follow the IDLE rules.
    - Otherwise: go to IDLE.
- mem_ack outside REQ is ignored.
- out_rd always equals the captured rd.

## Timing
- Reset values: in_ready=0 while rst high, 1 after; all other outputs 0; state=IDLE; watchdog=0.
- Reset mid-transaction drops mem_req and out_valid immediately (asynchronous). A pending ack is lost.
- Non-memory op accepted at cycle 0 → out_valid at cycle 1.
- Memory op accepted at cycle 0 → mem_req at cycle 1; mem_ack at cycle k≥1 → out_valid at cycle k+1.
- Minimum memory-op latency: 2 cycles.
- Throughput with zero-wait memory and out_ready held high: one memory op per 2 cycles; one non-memory op per cycle.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, and out_valid rises the following cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A ld/st with alu_result[1:0]≠0 skips REQ and goes straight to RESP with out_fault=1, out_wb_en=0.
  - No mem_req is issued, so latency is 1 cycle.
- MISALIGN_TRAP_EN undefined: the low two address bits are silently cleared and the access proceeds.

## Structure
- Shared package simplerisc_pkg holds:
  - mem_state_t enum (IDLE, REQ, RESP);
  - REG_IDX_W=4;
  - a writeback packet struct (data, rd, wb_en, fault).
- One sub-module, mem_watchdog, is natural: a saturating counter with clear and enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Pass-through: alu_result=0x0000_0007, wb_en=1, rd=3, out_ready=1 → out_valid at cycle 1 with out_data=7, out_rd=3, out_wb_en=1, and no mem_req.
- Load, 3-cycle wait: addr 0x100; mem_ack on the 3rd REQ cycle with rdata 0xDEAD_BEEF → mem_req high 3 cycles, mem_we=0, out_data=0xDEAD_BEEF, out_wb_en=1.
- Store then back-to-back load, out_ready held high: st 0x55 to 0x200, immediate ack, then ld → write seen at 0x200, out_wb_en=0 for the store, load issued in the same cycle the store's packet is accepted.
- Timeout: TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then out_fault=1, out_wb_en=0. A late ack in IDLE is ignored.
- Misaligned address 0x102: with MISALIGN_TRAP_EN → fault at cycle 1, no mem_req. Without it → mem_addr=0x100, normal completion.
- Reset asserted during REQ with out_ready low → mem_req and out_valid go 0 asynchronously; after release, in_ready=1 and a new op completes normally.
